// File: rtl/vga_frame_capture.sv
// VGA receiver: recovers pixel timing from h_sync/v_sync edges alone and streams
// every active pixel into a framebuffer write port; flags and recovers from broken timing.
module vga_frame_capture #(
  parameter int H_ACTIVE      = 640,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int H_TOTAL       = 800,
  parameter int V_ACTIVE      = 480,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33,
  parameter int V_TOTAL       = 525,
  parameter int ADDRESS_WIDTH = 19
) (
  input  logic                     clock_in,
  input  logic                     reset_n_in,
  input  logic                     pixel_enable_in,
  input  logic                     h_sync_in,
  input  logic                     v_sync_in,
  input  logic [3:0]               vga_red_in,
  input  logic [3:0]               vga_green_in,
  input  logic [3:0]               vga_blue_in,
  output logic                     memory_wr_out,
  output logic [ADDRESS_WIDTH-1:0] write_address_out,
  output logic [11:0]              data_out,
  output logic                     frame_done_out,
  output logic                     locked_out,
  output logic                     sync_error_out
);

  localparam int HCW     = $clog2(H_TOTAL + 1);
  localparam int VCW     = $clog2(V_TOTAL + 2);
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic                     hs_q, vs_q;
  logic [HCW-1:0]           hcount_q, hcount_d;
  logic [VCW-1:0]           vcount_q, vcount_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, waddr_q;
  logic [11:0]              data_q;
  logic                     wr_q, done_q, err_q;

  logic h_fall, v_fall, h_bad, v_bad, v_ok, overflow, in_window, last_px;
  logic timing_err, wr_en;

  always_comb begin
    h_fall = pixel_enable_in & hs_q & ~h_sync_in;
    v_fall = pixel_enable_in & vs_q & ~v_sync_in;
  end

  // Counter values describe the pixel being sampled on this tick.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pixel_enable_in) begin
      if (h_fall)
        hcount_d = '0;
      else if (hcount_q != HCW'(H_TOTAL))
        hcount_d = hcount_q + 1'b1;
      if (v_fall)
        vcount_d = '0;
      else if (h_fall && vcount_q != VCW'(V_TOTAL + 1))
        vcount_d = vcount_q + 1'b1;
    end
  end

  // v_sync may trail into the start of the following line's sync pulse.
  always_comb begin
    h_bad     = h_fall && (hcount_q != HCW'(H_TOTAL - 1));
    v_ok      = (vcount_q == VCW'(V_TOTAL - 1)) ||
                ((vcount_q == VCW'(V_TOTAL)) && (hcount_q < HCW'(H_SYNC)));
    v_bad     = v_fall && !v_ok;
    overflow  = pixel_enable_in &&
                ((hcount_d == HCW'(H_TOTAL)) || (vcount_d == VCW'(V_TOTAL + 1)));
    in_window = pixel_enable_in &&
                (hcount_d >= HCW'(H_START)) && (hcount_d < HCW'(H_START + H_ACTIVE)) &&
                (vcount_d >= VCW'(V_START)) && (vcount_d < VCW'(V_START + V_ACTIVE));
    last_px   = (hcount_d == HCW'(H_START + H_ACTIVE - 1)) &&
                (vcount_d == VCW'(V_START + V_ACTIVE - 1));
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) state_q <= UNLOCKED;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      UNLOCKED: if (v_fall)     state_d = LOCKED;
      LOCKED:   if (timing_err) state_d = UNLOCKED;
      default:                  state_d = UNLOCKED;
    endcase
  end

  always_comb begin
    timing_err = 1'b0;
    wr_en      = 1'b0;
    if (state_q == LOCKED) begin
      timing_err = h_bad | v_bad | overflow;
      wr_en      = in_window & ~timing_err;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      hcount_q <= '0;
      vcount_q <= '0;
      addr_q   <= '0;
      waddr_q  <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      if (pixel_enable_in) begin
        hs_q <= h_sync_in;
        vs_q <= v_sync_in;
      end
      wr_q   <= wr_en;
      done_q <= wr_en & last_px;
      err_q  <= timing_err;
      if (v_fall)
        addr_q <= '0;
      else if (wr_en)
        addr_q <= addr_q + 1'b1;
      if (wr_en) begin
        waddr_q <= addr_q;
        data_q  <= {vga_red_in, vga_green_in, vga_blue_in};
      end
    end
  end

  assign memory_wr_out     = wr_q;
  assign write_address_out = waddr_q;
  assign data_out          = data_q;
  assign frame_done_out    = done_q;
  assign sync_error_out    = err_q;
  assign locked_out        = (state_q == LOCKED);

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture on a shrunken 8x6 raster, with a
// per-clock reference model plus literal per-frame expectations.
module tb_vga_frame_capture;
  localparam int HA = 8, HS = 3, HB = 2, HT = 16;
  localparam int VA = 6, VS = 1, VB = 2, VT = 12;
  localparam int AW = 6;

  logic clk = 1'b0, rst_n = 1'b0, pe = 1'b0, hs = 1'b1, vs = 1'b1;
  logic [3:0] r = '0, g = '0, b = '0;
  logic          memory_wr_out, frame_done_out, locked_out, sync_error_out;
  logic [AW-1:0] write_address_out;
  logic [11:0]   data_out;

  always #5 clk = ~clk;

  vga_frame_capture #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT), .ADDRESS_WIDTH(AW)
  ) dut (
    .clock_in(clk), .reset_n_in(rst_n), .pixel_enable_in(pe),
    .h_sync_in(hs), .v_sync_in(vs),
    .vga_red_in(r), .vga_green_in(g), .vga_blue_in(b),
    .memory_wr_out(memory_wr_out), .write_address_out(write_address_out),
    .data_out(data_out), .frame_done_out(frame_done_out),
    .locked_out(locked_out), .sync_error_out(sync_error_out)
  );

  int n_checks = 0, n_fail = 0;

  // reference model state (positions as plain integers)
  int   m_hs, m_vs, m_hc, m_vc;
  bit   m_lock;
  bit   e_wr, e_fd, e_err, e_lock;
  int   e_addr;
  logic [11:0] e_data;

  // observed-output bookkeeping for the literal per-frame checks
  int   wr_cnt, fd_cnt, err_cnt, fd_addr;
  logic [11:0] mem [0:63];

  bit   cur_hs, cur_vs;
  logic [11:0] cur_rgb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hs = 1; m_vs = 1; m_hc = 0; m_vc = 0; m_lock = 0;
    e_wr = 0; e_fd = 0; e_err = 0; e_lock = 0; e_addr = 0; e_data = '0;
  endtask

  task automatic model_tick(input bit h, input bit v, input logic [11:0] rgb);
    bit hf, vf, err;
    int nhc, nvc, x, y;
    hf  = (m_hs == 1) && !h;
    vf  = (m_vs == 1) && !v;
    err = 0;
    if (m_lock) begin
      if (hf && m_hc != HT - 1) err = 1;
      if (vf && !(m_vc == VT - 1 || (m_vc == VT && m_hc < HS))) err = 1;
    end
    nhc = hf ? 0 : (m_hc < HT ? m_hc + 1 : HT);
    nvc = vf ? 0 : (hf ? (m_vc < VT + 1 ? m_vc + 1 : VT + 1) : m_vc);
    if (m_lock && (nhc == HT || nvc == VT + 1)) err = 1;
    x = nhc - (HS + HB);
    y = nvc - (VS + VB);
    e_wr  = m_lock && !err && x >= 0 && x < HA && y >= 0 && y < VA;
    e_err = err;
    e_fd  = 0;
    if (e_wr) begin
      e_addr = y * HA + x;
      e_data = rgb;
      e_fd   = (x == HA - 1) && (y == VA - 1);
    end
    m_lock = err ? 0 : (m_lock || vf);
    e_lock = m_lock;
    m_hs = h; m_vs = v; m_hc = nhc; m_vc = nvc;
  endtask

  task automatic compare();
    check("wr",     32'(memory_wr_out),     32'(e_wr));
    check("locked", 32'(locked_out),        32'(e_lock));
    check("error",  32'(sync_error_out),    32'(e_err));
    check("done",   32'(frame_done_out),    32'(e_fd));
    check("addr",   32'(write_address_out), e_addr);
    check("data",   32'(data_out),          32'(e_data));
    if (memory_wr_out === 1'b1) begin
      wr_cnt++;
      mem[write_address_out] = data_out;
    end
    if (frame_done_out === 1'b1) begin
      fd_cnt++;
      fd_addr = int'(write_address_out);
    end
    if (sync_error_out === 1'b1) err_cnt++;
  endtask

  task automatic cycle(input bit pe_v);
    @(posedge clk); #1;
    compare();
    rst_n = 1'b1;
    pe = pe_v;
    hs = cur_hs;
    vs = cur_vs;
    if (pe_v) begin
      {r, g, b} = cur_rgb;
      model_tick(cur_hs, cur_vs, cur_rgb);
    end else begin
      {r, g, b} = 12'($urandom);
      e_wr = 0; e_fd = 0; e_err = 0;
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    compare();
    rst_n = 1'b0;
    pe = 1'b0;
    model_reset();
    #1;
    check("rst_now_wr",     32'(memory_wr_out),     0);
    check("rst_now_locked", 32'(locked_out),        0);
    check("rst_now_addr",   32'(write_address_out), 0);
    check("rst_now_data",   32'(data_out),          0);
    repeat (2) begin
      @(posedge clk); #1;
      compare();
    end
  endtask

  task automatic clr();
    wr_cnt = 0; fd_cnt = 0; err_cnt = 0; fd_addr = -1;
    for (int i = 0; i < 64; i++) mem[i] = 12'hFFF;
  endtask

  // One frame of lines [start, nlines); optional short line, v_sync lag,
  // mid-frame reset point and lock-rise probe.
  task automatic send_frame(input int nlines, input int start, input int short_l,
                            input int lag, input int rst_l, input int rst_p, input bit chk_rise);
    int len, gi, x, y;
    logic [3:0] xs, ys;
    for (int l = start; l < nlines; l++) begin
      len = (l == short_l) ? HT - 1 : HT;
      for (int p = 0; p < len; p++) begin
        gi = l * HT + p;
        x  = p - (HS + HB);
        y  = l - (VS + VB);
        xs = 4'(x);
        ys = 4'(y);
        cur_hs  = (p >= HS);
        cur_vs  = !(gi >= lag && gi < VS * HT + lag);
        cur_rgb = {xs, ys, 4'hA};
        if (l == rst_l && p == rst_p) reset_pulse();
        cycle(1'b1);
        if (chk_rise && l == 0 && p == 0) check("lock_before_edge", 32'(locked_out), 0);
        cycle(1'b0);
        if (chk_rise && l == 0 && p == 0) check("lock_after_edge", 32'(locked_out), 1);
      end
    end
  endtask

  task automatic full_frame_checks(input string tag);
    check({tag, "_writes"},  wr_cnt, HA * VA);
    check({tag, "_done"},    fd_cnt, 1);
    check({tag, "_doneadr"}, fd_addr, HA * VA - 1);
    check({tag, "_errors"},  err_cnt, 0);
    check({tag, "_px53"},    32'(mem[29]), 32'h53A);
    check({tag, "_px00"},    32'(mem[0]),  32'h00A);
    check({tag, "_px75"},    32'(mem[47]), 32'h75A);
  endtask

  initial begin
    cur_hs = 1; cur_vs = 1; cur_rgb = '0;
    model_reset();
    clr();
    repeat (3) begin
      @(posedge clk); #1;
      compare();
    end
    check("reset_locked", 32'(locked_out), 0);
    check("reset_wr",     32'(memory_wr_out), 0);

    // stream joins mid-frame: nothing captured until v_sync falls
    send_frame(VT, 5, -1, 0, -1, -1, 1'b0);
    check("mid_writes", wr_cnt, 0);
    check("mid_locked", 32'(locked_out), 0);

    for (int f = 0; f < 2; f++) begin
      clr();
      send_frame(VT, 0, -1, 0, -1, -1, f == 0);
      full_frame_checks("nominal");
    end

    // line 6 (y=3) one tick short
    clr();
    send_frame(VT, 0, 6, 0, -1, -1, 1'b0);
    check("short_errors", err_cnt, 1);
    check("short_writes", wr_cnt, 32);
    check("short_done",   fd_cnt, 0);
    check("short_locked", 32'(locked_out), 0);
    clr();
    send_frame(VT, 0, -1, 0, -1, -1, 1'b0);
    full_frame_checks("relock1");

    // two extra lines without v_sync: vertical counter overruns
    clr();
    send_frame(VT + 2, 0, -1, 0, -1, -1, 1'b0);
    check("long_errors", err_cnt, 1);
    check("long_writes", wr_cnt, HA * VA);
    check("long_locked", 32'(locked_out), 0);
    clr();
    send_frame(VT, 0, -1, 0, -1, -1, 1'b0);
    full_frame_checks("relock2");

    // one extra line: the next v_sync edge is late and rejected, frame lost
    clr();
    send_frame(VT + 1, 0, -1, 0, -1, -1, 1'b0);
    check("plus1_writes", wr_cnt, HA * VA);
    check("plus1_errors", err_cnt, 0);
    clr();
    send_frame(VT, 0, -1, 0, -1, -1, 1'b0);
    check("lost_errors", err_cnt, 1);
    check("lost_writes", wr_cnt, 0);
    check("lost_done",   fd_cnt, 0);
    check("lost_locked", 32'(locked_out), 0);
    clr();
    send_frame(VT, 0, -1, 0, -1, -1, 1'b0);
    full_frame_checks("relock3");

    // v_sync trails h_sync by 2 ticks, still inside the h_sync pulse
    clr();
    send_frame(VT, 0, -1, 2, -1, -1, 1'b0);
    full_frame_checks("lag");

    // reset at pixel (4,3)
    clr();
    send_frame(VT, 0, -1, 0, 6, 9, 1'b0);
    check("rst_writes", wr_cnt, 28);
    check("rst_done",   fd_cnt, 0);
    check("rst_locked", 32'(locked_out), 0);
    clr();
    send_frame(VT, 0, -1, 0, -1, -1, 1'b0);
    full_frame_checks("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
